// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the KGP-RISC phase sequencer: phase indices, FSM state
// encoding and the reset phase length.
package cpu_phase_sequencer_pkg;

    localparam int unsigned NUM_PHASES = 5;

    localparam int unsigned PH_FETCH  = 0;
    localparam int unsigned PH_DECODE = 1;
    localparam int unsigned PH_EXEC   = 2;
    localparam int unsigned PH_MEM    = 3;
    localparam int unsigned PH_WB     = 4;

    localparam int unsigned KGP_DEFAULT_DIV = 8;

    // One-hot states; the encoding doubles as the phase output, IDLE is all-zero.
    typedef enum logic [NUM_PHASES-1:0] {
        StIdle   = 5'b00000,
        StFetch  = 5'b00001,
        StDecode = 5'b00010,
        StExec   = 5'b00100,
        StMem    = 5'b01000,
        StWb     = 5'b10000
    } state_e;

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// Control/status bundle between the datapath controller and the phase sequencer.
interface cpu_phase_sequencer_if
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W = 4
);

    logic                  run;
    logic                  halt_req;
    logic                  div_load;
    logic [DIV_W-1:0]      div_value;
    logic                  skip_mem;
    logic                  mem_ready;
    logic [NUM_PHASES-1:0] phase;
    logic [NUM_PHASES-1:0] stage_en;
    logic                  instr_done;
    logic                  busy;
    logic                  halted;
    logic [DIV_W-1:0]      div_active;

    modport master (
        output run, halt_req, div_load, div_value, skip_mem, mem_ready,
        input  phase, stage_en, instr_done, busy, halted, div_active
    );

    modport slave (
        input  run, halt_req, div_load, div_value, skip_mem, mem_ready,
        output phase, stage_en, instr_done, busy, halted, div_active
    );

endinterface

// File: rtl/cpu_phase_sequencer_phase_timer.sv
// Per-phase cycle counter: counts 0..limit, tc marks the terminal cycle.
module cpu_phase_sequencer_phase_timer #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hold,
    input  logic [DIV_W-1:0] limit,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Single-clock phase sequencer for the multi-cycle KGP-RISC datapath: emits one-hot
// phase and per-phase commit strobes, with programmable phase length, MEM stall and halt.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned DEFAULT_DIV = KGP_DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_phase_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic             skip_q, skip_d;
    logic             halt_pending_q, halt_pending_d;
    logic             halted_q, halted_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] div_pending_q, div_pending_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;

    logic tc;
    logic timer_clr;
    logic timer_hold;
    logic enter_idle;
    logic start_instr;

    cpu_phase_sequencer_phase_timer #(
        .DIV_W (DIV_W)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .hold  (timer_hold),
        .limit (div_active_q),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        unique case (state_q)
            StIdle: begin
                if (bus.run && !bus.halt_req) state_d = StFetch;
            end
            StFetch: begin
                if (tc) state_d = StDecode;
            end
            StDecode: begin
                if (tc) begin
                    state_d = StExec;
                    skip_d  = bus.skip_mem;
                end
            end
            StExec: begin
                if (tc) state_d = skip_q ? StWb : StMem;
            end
            StMem: begin
                if (tc && bus.mem_ready) state_d = StWb;
            end
            StWb: begin
                if (tc) begin
                    state_d = (bus.run && !halt_pending_q && !bus.halt_req) ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_idle  = (state_d == StIdle) && (state_q != StIdle);
    assign start_instr = (state_d == StFetch) && ((state_q == StIdle) || (state_q == StWb));

    // Counter parks at its terminal value while MEM waits for mem_ready.
    assign timer_clr  = (state_d != state_q) || (state_q == StIdle);
    assign timer_hold = (state_q == StMem) && tc && !bus.mem_ready;

    always_comb begin
        halt_pending_d = halt_pending_q;
        if (enter_idle) begin
            halt_pending_d = 1'b0;
        end else if (bus.halt_req && (state_q != StIdle)) begin
            halt_pending_d = 1'b1;
        end

        halted_d = halted_q;
        if ((state_q == StIdle) && (state_d == StFetch)) begin
            halted_d = 1'b0;
        end else if (enter_idle) begin
            halted_d = halt_pending_q || bus.halt_req;
        end

        div_pending_d = bus.div_load ? bus.div_value : div_pending_q;
        // Length only changes between instructions; a same-cycle load is forwarded.
        div_active_d  = div_active_q;
        if (start_instr) begin
            div_active_d = bus.div_load ? bus.div_value : div_pending_q;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            skip_q         <= 1'b0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            busy_q         <= 1'b0;
            div_pending_q  <= DIV_W'(DEFAULT_DIV);
            div_active_q   <= DIV_W'(DEFAULT_DIV);
        end else begin
            state_q        <= state_d;
            skip_q         <= skip_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
            busy_q         <= busy_d;
            div_pending_q  <= div_pending_d;
            div_active_q   <= div_active_d;
        end
    end

    logic [NUM_PHASES-1:0] stage_en;

    // MEM commits only on the cycle it actually ends, never during a stall.
    always_comb begin
        stage_en         = state_q & {NUM_PHASES{tc}};
        stage_en[PH_MEM] = stage_en[PH_MEM] & bus.mem_ready;
    end

    assign bus.phase      = state_q;
    assign bus.stage_en   = stage_en;
    assign bus.instr_done = stage_en[PH_WB];
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.div_active = div_active_q;

endmodule
